sram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one SRAM scratchpad (one access per cycle, 1-cycle registered read) among NUM_REQ requesters in the CNN PE, e.g. filter loader, input-feature loader and MAC read path. Each requester uses a valid/ready request channel and receives a one-cycle response pulse for reads. The block sits between PE-internal producers/consumers and the SRAM instance, drives the SRAM control/address/data pins, and flags out-of-range accesses.

---
 rtl/sram_port_arbiter_pkg.sv | 15 +
 rtl/sram_port_arbiter_rr_arbiter.sv | 25 ++
 rtl/sram_port_arbiter.sv | 73 +++++++
 tb/tb_sram_port_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared defaults and the round-robin winner search
package sram_port_arbiter_pkg;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REG = 24;
  localparam int MAX_REQ = 8;
  localparam int MAX_PW = 3;
  // Returns the first set request at or after ptr (modulo n), or -1 if none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    rr_pick = -1;
    for (int k = n - 1; k >= 0; k--)
      if (req[MAX_PW'((ptr + k) % n)]) rr_pick = (ptr + k) % n;
  endfunction
endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a pointer that moves past each winner
module rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx
);
  logic [PW-1:0] rr_ptr;
  int win;
  always_comb begin
    win = rr_pick(MAX_REQ'(req), int'(rr_ptr), NUM_REQ);
    grant = (win < 0) ? '0 : NUM_REQ'(1) << win;
    idx = (win < 0) ? '0 : PW'(win);
  end
  always_ff @(posedge clk)
    if (!rst_n) rr_ptr <= '0;
    else if (advance) rr_ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port among requesters, range-checks accesses, returns read data
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REG = DEF_NUM_REG,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          addr_err,
  output logic                          sram_chip_en,
  output logic                          sram_wen,
  output logic                          sram_ren,
  output logic [ADDR_WIDTH-1:0]         sram_waddr,
  output logic [ADDR_WIDTH-1:0]         sram_raddr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout
);
  logic [NUM_REQ-1:0] grant, rsp_valid_q;
  logic [PW-1:0] gidx;
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  logic sel_wr, hit, oor, en, rsp_oor_q, err_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // Requests are masked during reset so no grant or SRAM activity leaks out.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk,
    .rst_n,
    .req(req_valid & {NUM_REQ{rst_n}}),
    .advance(|grant),
    .grant,
    .idx(gidx)
  );
  always_comb begin
    sel_wr = req_wr[gidx];
    hit = |grant;
    oor = hit && int'(addr_a[gidx]) >= NUM_REG;
    en = hit && !oor;
    sram_chip_en = en;
    sram_wen = en && sel_wr;
    sram_ren = en && !sel_wr;
    sram_waddr = sram_wen ? addr_a[gidx] : '0;
    sram_din = sram_wen ? wdata_a[gidx] : '0;
    sram_raddr = sram_ren ? addr_a[gidx] : '0;
    req_ready = grant;
    rsp_valid = rst_n ? rsp_valid_q : '0;
    rsp_data = (|rsp_valid && !rsp_oor_q) ? sram_dout : '0;
    addr_err = err_q && rst_n;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rsp_valid_q <= sel_wr ? '0 : grant;
      rsp_oor_q <= oor;
      err_q <= err_q | oor;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vector table plus randomized traffic against a shadow memory
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] req_valid, req_ready, req_wr, rsp_valid;
  logic [14:0] req_addr;
  logic [47:0] req_wdata;
  logic [15:0] rsp_data, sram_din, sram_dout;
  logic addr_err, sram_chip_en, sram_wen, sram_ren;
  logic [4:0] sram_waddr, sram_raddr;
  logic [15:0] mem [32];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .addr_err(addr_err), .sram_chip_en(sram_chip_en), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_waddr(sram_waddr), .sram_raddr(sram_raddr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM with a registered read port
  always @(posedge clk) begin
    if (sram_chip_en && sram_wen) mem[sram_waddr] <= sram_din;
    if (sram_chip_en && sram_ren) sram_dout <= mem[sram_raddr];
  end

  typedef struct {
    logic rst;
    logic [2:0] v, w;
    logic [4:0] a0, a1, a2;
    logic [15:0] wd;
    logic [2:0] er, ers;
    logic [15:0] ed;
    logic ee, een;
  } vec_t;
  vec_t vq[$];

  task automatic row(input logic rst, input logic [2:0] v, w, input logic [4:0] a0, a1, a2,
                     input logic [15:0] wd, input logic [2:0] er, ers, input logic [15:0] ed,
                     input logic ee, een);
    vq.push_back('{rst, v, w, a0, a1, a2, wd, er, ers, ed, ee, een});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [15:0] shadow [24];
  logic [23:0] known;
  logic [2:0] eg, exp_rsp, gl;
  logic [15:0] exp_data;
  logic exp_known, err_m;
  int ptr_m;
  int wait_c [3];

  initial begin
    rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    // rst, valid, wr, a0, a1, a2, wdata | ready, rsp_valid, rsp_data, addr_err, chip_en
    row(0, 3'b111, 3'b000, 0, 0, 0, 16'h0000, 3'b000, 3'b000, 16'h0000, 0, 0);
    row(0, 3'b111, 3'b000, 0, 0, 0, 16'h0000, 3'b000, 3'b000, 16'h0000, 0, 0);
    row(1, 3'b111, 3'b111, 0, 1, 2, 16'h1111, 3'b001, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b111, 3'b111, 0, 1, 2, 16'h2222, 3'b010, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b111, 3'b111, 0, 1, 2, 16'h3333, 3'b100, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b111, 3'b111, 0, 1, 2, 16'h4444, 3'b001, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b010, 3'b010, 0, 5, 0, 16'hBEEF, 3'b010, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b100, 3'b000, 0, 0, 5, 16'h0000, 3'b100, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b000, 3'b000, 0, 0, 0, 16'h0000, 3'b000, 3'b100, 16'hBEEF, 0, 0);
    row(1, 3'b001, 3'b000, 24, 0, 0, 16'h0000, 3'b001, 3'b000, 16'h0000, 0, 0);
    row(1, 3'b000, 3'b000, 0, 0, 0, 16'h0000, 3'b000, 3'b001, 16'h0000, 1, 0);
    row(1, 3'b100, 3'b000, 0, 0, 5, 16'h0000, 3'b100, 3'b000, 16'h0000, 1, 1);
    for (int i = 0; i < 3; i++)
      row(1, 3'b100, 3'b000, 0, 0, 5, 16'h0000, 3'b100, 3'b100, 16'hBEEF, 1, 1);
    row(1, 3'b101, 3'b000, 1, 0, 5, 16'h0000, 3'b001, 3'b100, 16'hBEEF, 1, 1);
    row(1, 3'b100, 3'b000, 0, 0, 5, 16'h0000, 3'b100, 3'b001, 16'h2222, 1, 1);
    row(1, 3'b001, 3'b000, 2, 0, 0, 16'h0000, 3'b001, 3'b100, 16'hBEEF, 1, 1);
    row(0, 3'b111, 3'b000, 1, 2, 3, 16'h0000, 3'b000, 3'b000, 16'h0000, 0, 0);
    row(1, 3'b011, 3'b000, 0, 1, 0, 16'h0000, 3'b001, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b001, 3'b001, 23, 0, 0, 16'h1234, 3'b001, 3'b001, 16'h4444, 0, 1);
    row(1, 3'b010, 3'b000, 0, 23, 0, 16'h0000, 3'b010, 3'b000, 16'h0000, 0, 1);
    row(1, 3'b000, 3'b000, 0, 0, 0, 16'h0000, 3'b000, 3'b010, 16'h1234, 0, 0);
    row(1, 3'b010, 3'b010, 0, 31, 0, 16'hFFFF, 3'b010, 3'b000, 16'h0000, 0, 0);
    row(1, 3'b000, 3'b000, 0, 0, 0, 16'h0000, 3'b000, 3'b000, 16'h0000, 1, 0);

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      rst_n = vq[i].rst;
      req_valid = vq[i].v;
      req_wr = vq[i].w;
      req_addr = {vq[i].a2, vq[i].a1, vq[i].a0};
      req_wdata = {3{vq[i].wd}};
      #4;
      chk($sformatf("row%0d_ready", i), req_ready, vq[i].er);
      chk($sformatf("row%0d_rsp_valid", i), rsp_valid, vq[i].ers);
      if (vq[i].ers != 0 || !vq[i].rst) chk($sformatf("row%0d_rsp_data", i), rsp_data, vq[i].ed);
      chk($sformatf("row%0d_addr_err", i), addr_err, vq[i].ee);
      chk($sformatf("row%0d_chip_en", i), sram_chip_en, vq[i].een);
      if (!vq[i].rst) chk($sformatf("row%0d_sram_ctl", i),
                          {sram_wen, sram_ren, sram_waddr, sram_raddr, sram_din}, 0);
    end

    // Randomized traffic: requesters hold until granted, shadow memory predicts read data
    @(posedge clk);
    #1;
    rst_n = 1'b0; req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr_m = 0; exp_rsp = '0; exp_data = '0; exp_known = 1'b0; err_m = 1'b0; gl = '0; known = '0;
    for (int i = 0; i < 3; i++) wait_c[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 3; i++)
        if (!req_valid[i] || gl[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_wr[i] = 1'($urandom_range(0, 1));
          req_addr[i*5 +: 5] = 5'($urandom_range(0, 25));
          req_wdata[i*16 +: 16] = 16'($urandom);
        end
      #4;
      eg = '0;
      for (int k = 2; k >= 0; k--)
        if (req_valid[(ptr_m + k) % 3]) eg = 3'b001 << ((ptr_m + k) % 3);
      chk("rnd_ready", req_ready, eg);
      chk("rnd_rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != 0 && exp_known) chk("rnd_rsp_data", rsp_data, exp_data);
      chk("rnd_addr_err", addr_err, err_m);
      exp_rsp = '0;
      for (int i = 0; i < 3; i++)
        if (eg[i]) begin
          ptr_m = (i + 1) % 3;
          if (req_addr[i*5 +: 5] >= 24) err_m = 1'b1;
          if (req_wr[i]) begin
            if (req_addr[i*5 +: 5] < 24) begin
              shadow[req_addr[i*5 +: 5]] = req_wdata[i*16 +: 16];
              known[req_addr[i*5 +: 5]] = 1'b1;
            end
          end else begin
            exp_rsp = eg;
            exp_known = (req_addr[i*5 +: 5] >= 24) || known[req_addr[i*5 +: 5]];
            exp_data = (req_addr[i*5 +: 5] < 24) ? shadow[req_addr[i*5 +: 5]] : 16'h0000;
          end
        end
      gl = req_ready;
      for (int i = 0; i < 3; i++) begin
        wait_c[i] = (req_valid[i] && !req_ready[i]) ? wait_c[i] + 1 : 0;
        chk($sformatf("rnd_starve%0d", i), 32'(wait_c[i] < 3), 1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
